// File: rtl/sdram_req_gen.sv
// Burst request generator for the SDRAM controller: raises write/read burst requests
// from FIFO fill levels and walks burst addresses through a ping-pong frame store.
module sdram_req_gen #(
   parameter int BURST_LEN    = 512,
   parameter int FIFO_DEPTH   = 1024,
   parameter int FRAME_BURSTS = 600,
   parameter int IDX_W        = 10,
   parameter int GAP_CYC      = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init_done,
   input  logic [10:0]      wfifo_rdusedw,
   input  logic [10:0]      rfifo_wrusedw,
   input  logic             wr_frame_start,
   input  logic             rd_frame_start,
   output logic             wr_sdram_req,
   input  logic             wr_sdram_ack,
   output logic             rd_sdram_req,
   input  logic             rd_sdram_ack,
   output logic [IDX_W:0]   wr_addr,
   output logic [IDX_W:0]   rd_addr
);

   localparam int CNT_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   typedef enum logic [1:0] {S_SYNC, S_ARM, S_REQ, S_GAP} state_t;

   state_t             r_wr_state, w_wr_state_nxt, r_rd_state, w_rd_state_nxt;
   logic [CNT_W-1:0]   r_wr_cnt, w_wr_cnt_nxt, r_rd_cnt, w_rd_cnt_nxt;
   logic [IDX_W-1:0]   r_wr_idx, w_wr_idx_nxt, r_rd_idx, w_rd_idx_nxt;
   logic               r_wr_buf, w_wr_buf_nxt, r_rd_buf, w_rd_buf_nxt;
   logic               r_wr_pend, w_wr_pend_nxt, r_rd_pend, w_rd_pend_nxt;
   logic               r_done_buf, w_done_buf_nxt;
   logic               r_frame_valid, w_frame_valid_nxt;
   logic               r_wr_req, r_rd_req;
   logic               w_wr_ready, w_rd_ready, w_wr_gap_end, w_rd_gap_end;

   assign w_wr_ready   = init_done && (wfifo_rdusedw >= 11'(BURST_LEN));
   assign w_rd_ready   = init_done && (rfifo_wrusedw <= 11'(FIFO_DEPTH - BURST_LEN));
   assign w_wr_gap_end = (r_wr_cnt == CNT_W'(GAP_CYC - 1));
   assign w_rd_gap_end = (r_rd_cnt == CNT_W'(GAP_CYC - 1));

   // Write channel: a frame start in REQ is deferred so the request is never withdrawn.
   always_comb begin
      w_wr_state_nxt    = r_wr_state;
      w_wr_cnt_nxt      = r_wr_cnt;
      w_wr_idx_nxt      = r_wr_idx;
      w_wr_buf_nxt      = r_wr_buf;
      w_wr_pend_nxt     = r_wr_pend;
      w_done_buf_nxt    = r_done_buf;
      w_frame_valid_nxt = r_frame_valid;
      case (r_wr_state)
         S_SYNC: if (init_done && wr_frame_start) begin
            w_wr_state_nxt = S_ARM;
            w_wr_idx_nxt   = '0;
         end
         S_ARM: begin
            if (wr_frame_start) w_wr_idx_nxt = '0;
            if (w_wr_ready)     w_wr_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (wr_sdram_ack) begin
               w_wr_state_nxt = S_GAP;
               w_wr_cnt_nxt   = '0;
               w_wr_pend_nxt  = 1'b0;
               w_wr_idx_nxt   = (r_wr_pend || wr_frame_start) ? '0 : r_wr_idx + IDX_W'(1);
            end else if (wr_frame_start) begin
               w_wr_pend_nxt = 1'b1;
            end
         end
         S_GAP: begin
            if (!w_wr_gap_end) begin
               w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
               if (wr_frame_start) w_wr_idx_nxt = '0;
            end else if (wr_frame_start) begin
               w_wr_idx_nxt   = '0;
               w_wr_state_nxt = S_ARM;
            end else if (r_wr_idx == IDX_W'(FRAME_BURSTS)) begin
               w_done_buf_nxt    = r_wr_buf;
               w_wr_buf_nxt      = ~r_wr_buf;
               w_wr_idx_nxt      = '0;
               w_frame_valid_nxt = 1'b1;
               w_wr_state_nxt    = S_SYNC;
            end else begin
               w_wr_state_nxt = S_ARM;
            end
         end
         default: w_wr_state_nxt = S_SYNC;
      endcase
   end

   // Read channel: every restart re-points at the most recently completed frame.
   always_comb begin
      w_rd_state_nxt = r_rd_state;
      w_rd_cnt_nxt   = r_rd_cnt;
      w_rd_idx_nxt   = r_rd_idx;
      w_rd_buf_nxt   = r_rd_buf;
      w_rd_pend_nxt  = r_rd_pend;
      case (r_rd_state)
         S_SYNC: if (init_done && rd_frame_start && r_frame_valid) begin
            w_rd_state_nxt = S_ARM;
            w_rd_idx_nxt   = '0;
            w_rd_buf_nxt   = r_done_buf;
         end
         S_ARM: begin
            if (rd_frame_start) begin
               w_rd_idx_nxt = '0;
               w_rd_buf_nxt = r_done_buf;
            end
            if (w_rd_ready) w_rd_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (rd_sdram_ack) begin
               w_rd_state_nxt = S_GAP;
               w_rd_cnt_nxt   = '0;
               w_rd_pend_nxt  = 1'b0;
               if (r_rd_pend || rd_frame_start) begin
                  w_rd_idx_nxt = '0;
                  w_rd_buf_nxt = r_done_buf;
               end else begin
                  w_rd_idx_nxt = r_rd_idx + IDX_W'(1);
               end
            end else if (rd_frame_start) begin
               w_rd_pend_nxt = 1'b1;
            end
         end
         S_GAP: begin
            if (rd_frame_start) begin
               w_rd_idx_nxt = '0;
               w_rd_buf_nxt = r_done_buf;
            end
            if (!w_rd_gap_end)
               w_rd_cnt_nxt = r_rd_cnt + CNT_W'(1);
            else if (!rd_frame_start && r_rd_idx == IDX_W'(FRAME_BURSTS))
               w_rd_state_nxt = S_SYNC;
            else
               w_rd_state_nxt = S_ARM;
         end
         default: w_rd_state_nxt = S_SYNC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_state    <= S_SYNC;
         r_rd_state    <= S_SYNC;
         r_wr_cnt      <= '0;
         r_rd_cnt      <= '0;
         r_wr_idx      <= '0;
         r_rd_idx      <= '0;
         r_wr_buf      <= 1'b0;
         r_rd_buf      <= 1'b0;
         r_wr_pend     <= 1'b0;
         r_rd_pend     <= 1'b0;
         r_done_buf    <= 1'b0;
         r_frame_valid <= 1'b0;
         r_wr_req      <= 1'b0;
         r_rd_req      <= 1'b0;
      end else begin
         r_wr_state    <= w_wr_state_nxt;
         r_rd_state    <= w_rd_state_nxt;
         r_wr_cnt      <= w_wr_cnt_nxt;
         r_rd_cnt      <= w_rd_cnt_nxt;
         r_wr_idx      <= w_wr_idx_nxt;
         r_rd_idx      <= w_rd_idx_nxt;
         r_wr_buf      <= w_wr_buf_nxt;
         r_rd_buf      <= w_rd_buf_nxt;
         r_wr_pend     <= w_wr_pend_nxt;
         r_rd_pend     <= w_rd_pend_nxt;
         r_done_buf    <= w_done_buf_nxt;
         r_frame_valid <= w_frame_valid_nxt;
         r_wr_req      <= (w_wr_state_nxt == S_REQ);
         r_rd_req      <= (w_rd_state_nxt == S_REQ);
      end
   end

   assign wr_sdram_req = r_wr_req;
   assign rd_sdram_req = r_rd_req;
   assign wr_addr      = {r_wr_buf, r_wr_idx};
   assign rd_addr      = {r_rd_buf, r_rd_idx};

endmodule

// File: tb/tb_sdram_req_gen.sv
// Scenario bench for sdram_req_gen: randomized FIFO levels and ack delays, checked
// against a burst-counter model of the ping-pong frame store.
module tb_sdram_req_gen;

   localparam int BURST_LEN    = 512;
   localparam int FIFO_DEPTH   = 1024;
   localparam int FRAME_BURSTS = 600;
   localparam int IDX_W        = 10;
   localparam int GAP_CYC      = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             init_done = 1'b0;
   logic [10:0]      wfifo_rdusedw = '0;
   logic [10:0]      rfifo_wrusedw = '0;
   logic             wr_frame_start = 1'b0;
   logic             rd_frame_start = 1'b0;
   logic             wr_sdram_ack = 1'b0;
   logic             rd_sdram_ack = 1'b0;
   logic             wr_sdram_req, rd_sdram_req;
   logic [IDX_W:0]   wr_addr, rd_addr;

   sdram_req_gen #(
      .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH), .FRAME_BURSTS(FRAME_BURSTS),
      .IDX_W(IDX_W), .GAP_CYC(GAP_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .init_done(init_done),
      .wfifo_rdusedw(wfifo_rdusedw), .rfifo_wrusedw(rfifo_wrusedw),
      .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
      .wr_sdram_req(wr_sdram_req), .wr_sdram_ack(wr_sdram_ack),
      .rd_sdram_req(rd_sdram_req), .rd_sdram_ack(rd_sdram_ack),
      .wr_addr(wr_addr), .rd_addr(rd_addr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // model: burst counts per channel and which buffer holds the last finished frame
   logic m_wr_buf, m_rd_buf, m_done_buf, m_fv;
   int   m_wr_cnt, m_rd_cnt;

   function automatic logic [IDX_W:0] mk(input logic b, input int c);
      return {b, IDX_W'(c)};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_wr_fs();
      wr_frame_start = 1'b1; tick(); wr_frame_start = 1'b0;
   endtask

   task automatic pulse_rd_fs();
      rd_frame_start = 1'b1; tick(); rd_frame_start = 1'b0;
   endtask

   task automatic pulse_wr_ack();
      wr_sdram_ack = 1'b1; tick(); wr_sdram_ack = 1'b0;
   endtask

   task automatic pulse_rd_ack();
      rd_sdram_ack = 1'b1; tick(); rd_sdram_ack = 1'b0;
   endtask

   // Serves n write bursts with random ack latency; counts timeouts and wrong addresses.
   task automatic run_wr_bursts(input int n, output int bad);
      int w;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         w = 0;
         while (wr_sdram_req !== 1'b1 && w < 40) begin tick(); w++; end
         if (wr_sdram_req !== 1'b1) begin bad++; break; end
         if (wr_addr !== mk(m_wr_buf, m_wr_cnt)) bad++;
         repeat ($urandom_range(0, 3)) tick();
         wfifo_rdusedw = 11'($urandom_range(BURST_LEN, FIFO_DEPTH));
         pulse_wr_ack();
         m_wr_cnt++;
         if (m_wr_cnt == FRAME_BURSTS) begin
            m_done_buf = m_wr_buf;
            m_wr_buf   = ~m_wr_buf;
            m_wr_cnt   = 0;
            m_fv       = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      m_wr_buf = 0; m_rd_buf = 0; m_done_buf = 0; m_fv = 0; m_wr_cnt = 0; m_rd_cnt = 0;
      rst_n = 1'b0; tick(); tick();
      n_cmp++; if ({wr_sdram_req, rd_sdram_req} !== 2'b00) begin n_err++;
         $display("FAIL reset_req: got %b expected 00", {wr_sdram_req, rd_sdram_req}); end
      n_cmp++; if (wr_addr !== '0) begin n_err++;
         $display("FAIL reset_wr_addr: got %0h expected 0", wr_addr); end
      n_cmp++; if (rd_addr !== '0) begin n_err++;
         $display("FAIL reset_rd_addr: got %0h expected 0", rd_addr); end
      rst_n = 1'b1; tick();
      wfifo_rdusedw = 11'd1024;
      pulse_wr_fs();
      repeat (5) tick();
      n_cmp++; if (wr_sdram_req !== 1'b0) begin n_err++;
         $display("FAIL no_init_req: got %b expected 0", wr_sdram_req); end
      init_done = 1'b1;
      repeat (5) tick();
      n_cmp++; if (wr_sdram_req !== 1'b0) begin n_err++;
         $display("FAIL no_frame_start_req: got %b expected 0", wr_sdram_req); end
   endtask

   task automatic test_threshold();
      int k;
      wfifo_rdusedw = 11'($urandom_range(0, BURST_LEN - 1));
      pulse_wr_fs();
      k = $urandom_range(3, 8);
      for (int i = 0; i < k; i++) begin
         wfifo_rdusedw = (i == 0) ? 11'(BURST_LEN - 1) : 11'($urandom_range(0, BURST_LEN - 1));
         tick();
         n_cmp++; if (wr_sdram_req !== 1'b0) begin n_err++;
            $display("FAIL below_threshold: usedw %0d got %b expected 0", wfifo_rdusedw, wr_sdram_req); end
      end
      wfifo_rdusedw = 11'(BURST_LEN);
      tick();
      n_cmp++; if (wr_sdram_req !== 1'b1) begin n_err++;
         $display("FAIL at_threshold: got %b expected 1", wr_sdram_req); end
      n_cmp++; if (wr_addr !== mk(0, 0)) begin n_err++;
         $display("FAIL first_wr_addr: got %0h expected %0h", wr_addr, mk(0, 0)); end
   endtask

   task automatic test_handshake();
      int n;
      repeat ($urandom_range(20, 600)) begin
         wfifo_rdusedw = 11'($urandom_range(0, FIFO_DEPTH));
         tick();
      end
      n_cmp++; if (wr_sdram_req !== 1'b1 || wr_addr !== mk(0, 0)) begin n_err++;
         $display("FAIL req_held: got req %b addr %0h expected 1 / %0h", wr_sdram_req, wr_addr, mk(0, 0)); end
      wfifo_rdusedw = 11'd1024;
      pulse_wr_ack();
      m_wr_cnt = 1;
      n_cmp++; if (wr_sdram_req !== 1'b0) begin n_err++;
         $display("FAIL req_fall: got %b expected 0", wr_sdram_req); end
      n_cmp++; if (wr_addr !== mk(m_wr_buf, m_wr_cnt)) begin n_err++;
         $display("FAIL addr_after_ack: got %0h expected %0h", wr_addr, mk(m_wr_buf, m_wr_cnt)); end
      n = 1;
      while (wr_sdram_req === 1'b0 && n < 50) begin tick(); if (wr_sdram_req === 1'b0) n++; end
      n_cmp++; if (n !== GAP_CYC + 1) begin n_err++;
         $display("FAIL gap_len: got %0d low cycles expected %0d", n, GAP_CYC + 1); end
      n_cmp++; if (wr_addr !== mk(m_wr_buf, m_wr_cnt)) begin n_err++;
         $display("FAIL second_req_addr: got %0h expected %0h", wr_addr, mk(m_wr_buf, m_wr_cnt)); end
   endtask

   task automatic test_read_invalid();
      rfifo_wrusedw = '0;
      pulse_rd_fs();
      repeat (8) tick();
      n_cmp++; if (rd_sdram_req !== 1'b0 || rd_addr !== '0) begin n_err++;
         $display("FAIL read_before_valid: got req %b addr %0h expected 0 / 0", rd_sdram_req, rd_addr); end
   endtask

   task automatic test_frame_wrap();
      int bad;
      run_wr_bursts(FRAME_BURSTS - 1, bad);
      n_cmp++; if (bad !== 0) begin n_err++;
         $display("FAIL frame_bursts: got %0d bad bursts expected 0", bad); end
      repeat (GAP_CYC + 2) tick();
      n_cmp++; if (wr_addr !== mk(m_wr_buf, 0) || m_wr_buf !== 1'b1) begin n_err++;
         $display("FAIL wrap_addr: got %0h expected %0h", wr_addr, mk(1, 0)); end
      wfifo_rdusedw = 11'd1024;
      repeat (10) tick();
      n_cmp++; if (wr_sdram_req !== 1'b0) begin n_err++;
         $display("FAIL wait_sync: got %b expected 0", wr_sdram_req); end
   endtask

   task automatic test_read();
      rfifo_wrusedw = 11'($urandom_range(FIFO_DEPTH - BURST_LEN + 1, FIFO_DEPTH));
      pulse_rd_fs();
      m_rd_buf = m_done_buf; m_rd_cnt = 0;
      repeat ($urandom_range(2, 6)) tick();
      n_cmp++; if (rd_sdram_req !== 1'b0) begin n_err++;
         $display("FAIL read_above_level: usedw %0d got %b expected 0", rfifo_wrusedw, rd_sdram_req); end
      rfifo_wrusedw = ($urandom_range(0, 1) == 1) ? 11'(FIFO_DEPTH - BURST_LEN)
                                                  : 11'($urandom_range(0, FIFO_DEPTH - BURST_LEN));
      tick();
      n_cmp++; if (rd_sdram_req !== 1'b1 || rd_addr !== mk(m_rd_buf, m_rd_cnt)) begin n_err++;
         $display("FAIL read_req: got req %b addr %0h expected 1 / %0h", rd_sdram_req, rd_addr, mk(m_rd_buf, m_rd_cnt)); end
   endtask

   task automatic test_simultaneous();
      rfifo_wrusedw = 11'd1000;
      pulse_rd_ack();
      m_rd_cnt++;
      repeat (GAP_CYC + 3) tick();
      n_cmp++; if (rd_sdram_req !== 1'b0 || rd_addr !== mk(m_rd_buf, m_rd_cnt)) begin n_err++;
         $display("FAIL read_after_ack: got req %b addr %0h expected 0 / %0h", rd_sdram_req, rd_addr, mk(m_rd_buf, m_rd_cnt)); end
      wfifo_rdusedw = '0;
      pulse_wr_fs();
      m_wr_cnt = 0;
      tick();
      wfifo_rdusedw = 11'($urandom_range(BURST_LEN, FIFO_DEPTH));
      rfifo_wrusedw = 11'($urandom_range(0, FIFO_DEPTH - BURST_LEN));
      tick();
      n_cmp++; if ({wr_sdram_req, rd_sdram_req} !== 2'b11) begin n_err++;
         $display("FAIL both_req: got %b expected 11", {wr_sdram_req, rd_sdram_req}); end
      n_cmp++; if (wr_addr !== mk(m_wr_buf, m_wr_cnt) || rd_addr !== mk(m_rd_buf, m_rd_cnt)) begin n_err++;
         $display("FAIL both_addr: got %0h/%0h expected %0h/%0h", wr_addr, rd_addr, mk(m_wr_buf, m_wr_cnt), mk(m_rd_buf, m_rd_cnt)); end
   endtask

   task automatic test_ignored_ack();
      rfifo_wrusedw = 11'($urandom_range(FIFO_DEPTH - BURST_LEN + 1, FIFO_DEPTH));
      pulse_rd_ack();
      m_rd_cnt++;
      repeat (GAP_CYC + 3) tick();
      pulse_rd_ack();
      repeat (3) tick();
      n_cmp++; if (rd_sdram_req !== 1'b0 || rd_addr !== mk(m_rd_buf, m_rd_cnt)) begin n_err++;
         $display("FAIL stray_ack: got req %b addr %0h expected 0 / %0h", rd_sdram_req, rd_addr, mk(m_rd_buf, m_rd_cnt)); end
   endtask

   task automatic test_midframe_wr();
      int bad, tgt, w;
      tgt = $urandom_range(2, 60);
      run_wr_bursts(tgt, bad);
      n_cmp++; if (bad !== 0) begin n_err++;
         $display("FAIL mid_bursts: got %0d bad bursts expected 0", bad); end
      w = 0;
      while (wr_sdram_req !== 1'b1 && w < 40) begin tick(); w++; end
      pulse_wr_fs();
      repeat ($urandom_range(1, 5)) tick();
      n_cmp++; if (wr_sdram_req !== 1'b1 || wr_addr !== mk(m_wr_buf, tgt)) begin n_err++;
         $display("FAIL fs_in_req_hold: got req %b addr %0h expected 1 / %0h", wr_sdram_req, wr_addr, mk(m_wr_buf, tgt)); end
      pulse_wr_ack();
      m_wr_cnt = 0;
      n_cmp++; if (wr_sdram_req !== 1'b0 || wr_addr !== mk(m_wr_buf, 0)) begin n_err++;
         $display("FAIL fs_restart: got req %b addr %0h expected 0 / %0h", wr_sdram_req, wr_addr, mk(m_wr_buf, 0)); end
      w = 0;
      while (wr_sdram_req !== 1'b1 && w < 40) begin tick(); w++; end
      n_cmp++; if (wr_sdram_req !== 1'b1 || wr_addr !== mk(m_wr_buf, 0)) begin n_err++;
         $display("FAIL fs_reissue: got req %b addr %0h expected 1 / %0h", wr_sdram_req, wr_addr, mk(m_wr_buf, 0)); end
   endtask

   task automatic test_midframe_rd();
      int bad, w;
      run_wr_bursts(FRAME_BURSTS, bad);
      n_cmp++; if (bad !== 0) begin n_err++;
         $display("FAIL second_frame: got %0d bad bursts expected 0", bad); end
      repeat (GAP_CYC + 2) tick();
      n_cmp++; if (wr_addr !== mk(m_wr_buf, 0) || rd_addr !== mk(m_rd_buf, m_rd_cnt)) begin n_err++;
         $display("FAIL second_wrap: got %0h/%0h expected %0h/%0h", wr_addr, rd_addr, mk(m_wr_buf, 0), mk(m_rd_buf, m_rd_cnt)); end
      pulse_rd_fs();
      m_rd_buf = m_done_buf; m_rd_cnt = 0;
      n_cmp++; if (rd_addr !== mk(m_rd_buf, m_rd_cnt)) begin n_err++;
         $display("FAIL rd_fs_in_arm: got %0h expected %0h", rd_addr, mk(m_rd_buf, m_rd_cnt)); end
      rfifo_wrusedw = 11'($urandom_range(0, FIFO_DEPTH - BURST_LEN));
      tick();
      pulse_rd_ack();
      m_rd_cnt = 1;
      w = 0;
      while (rd_sdram_req !== 1'b1 && w < 40) begin tick(); w++; end
      n_cmp++; if (rd_sdram_req !== 1'b1 || rd_addr !== mk(m_rd_buf, m_rd_cnt)) begin n_err++;
         $display("FAIL rd_next: got req %b addr %0h expected 1 / %0h", rd_sdram_req, rd_addr, mk(m_rd_buf, m_rd_cnt)); end
      pulse_rd_fs();
      tick();
      n_cmp++; if (rd_sdram_req !== 1'b1 || rd_addr !== mk(m_rd_buf, m_rd_cnt)) begin n_err++;
         $display("FAIL rd_fs_in_req: got req %b addr %0h expected 1 / %0h", rd_sdram_req, rd_addr, mk(m_rd_buf, m_rd_cnt)); end
      pulse_rd_ack();
      m_rd_buf = m_done_buf; m_rd_cnt = 0;
      n_cmp++; if (rd_sdram_req !== 1'b0 || rd_addr !== mk(m_rd_buf, m_rd_cnt)) begin n_err++;
         $display("FAIL rd_restart: got req %b addr %0h expected 0 / %0h", rd_sdram_req, rd_addr, mk(m_rd_buf, m_rd_cnt)); end
   endtask

   task automatic test_reset_midop();
      int w;
      wfifo_rdusedw = 11'd1024;
      pulse_wr_fs();
      w = 0;
      while (wr_sdram_req !== 1'b1 && w < 40) begin tick(); w++; end
      pulse_wr_ack();
      repeat (GAP_CYC + 3) tick();
      n_cmp++; if ({wr_sdram_req, rd_sdram_req} !== 2'b11 || rd_addr === '0) begin n_err++;
         $display("FAIL pre_reset: got req %b rd_addr %0h expected 11 / nonzero", {wr_sdram_req, rd_sdram_req}, rd_addr); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({wr_sdram_req, rd_sdram_req} !== 2'b00) begin n_err++;
         $display("FAIL async_reset_req: got %b expected 00", {wr_sdram_req, rd_sdram_req}); end
      n_cmp++; if (wr_addr !== '0 || rd_addr !== '0) begin n_err++;
         $display("FAIL async_reset_addr: got %0h/%0h expected 0/0", wr_addr, rd_addr); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_threshold();
      test_handshake();
      test_read_invalid();
      test_frame_wrap();
      test_read();
      test_simultaneous();
      test_ignored_ack();
      test_midframe_wr();
      test_midframe_rd();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sdram_req_gen.md
# sdram_req_gen

Burst request generator that sits directly upstream of the SDRAM controller. It watches the camera-side write FIFO and the display-side read FIFO, raises `wr_sdram_req` / `rd_sdram_req` whenever a full 512-word burst can be moved, and holds each request until the controller's one-cycle ack. It also keeps per-channel burst addresses within a two-buffer (ping-pong) frame store, so the display always reads the most recently completed camera frame.

## Interface
- `BURST_LEN`, 512: words per burst; matches the controller's write/read burst length.
- `FIFO_DEPTH`, 1024: depth of each FIFO, in words.
- `FRAME_BURSTS`, 600: bursts per frame (640×480 / 512).
- `IDX_W`, 10: width of the burst index; must satisfy 2^IDX_W ≥ FRAME_BURSTS.
- `GAP_CYC`, 4: minimum low cycles on a request after its ack, to absorb FIFO usedw lag.

Ports:
- `clk` in 1: system/SDRAM clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `init_done` in 1: the controller has finished SDRAM initialisation. No request is raised while this is low.
- `wfifo_rdusedw` in 11: words currently held in the write FIFO.
- `rfifo_wrusedw` in 11: words currently held in the read FIFO.
- `wr_frame_start` in 1: single-cycle camera vsync pulse, already synchronised to `clk`.
- `rd_frame_start` in 1: single-cycle display vsync pulse, already synchronised to `clk`.
- `wr_sdram_req` out 1: write-burst request.
- `wr_sdram_ack` in 1: one-cycle pulse meaning the write burst is complete.
- `rd_sdram_req` out 1: read-burst request.
- `rd_sdram_ack` in 1: one-cycle pulse meaning the read burst is complete.
- `wr_addr` out IDX_W+1: `{wr_buf, wr_idx}`, the burst address for the pending write.
- `rd_addr` out IDX_W+1: `{rd_buf, rd_idx}`, the burst address for the pending read.

## Operation
- The write channel and read channel each run an independent state machine with states SYNC, ARM, REQ, GAP.
- **Write channel**
  - SYNC: wait for `init_done` and `wr_frame_start`, then go to ARM with `wr_idx`=0.
  - ARM: when `wfifo_rdusedw` ≥ BURST_LEN, go to REQ.
  - REQ: `wr_sdram_req`=1. On `wr_sdram_ack`, go to GAP and increment `wr_idx`.
  - GAP: hold GAP_CYC cycles.
    - If `wr_idx` == FRAME_BURSTS, set `done_buf` ← `wr_buf`, toggle `wr_buf`, clear `wr_idx`, and go to SYNC.
    - Otherwise go to ARM.
- **Read channel**
  - SYNC: wait for `init_done`, `rd_frame_start`, and `frame_valid`=1. Then set `rd_buf` ← `done_buf`, `rd_idx`=0, and go to ARM.
  - ARM: when `rfifo_wrusedw` ≤ FIFO_DEPTH − BURST_LEN, go to REQ.
  - REQ: `rd_sdram_req`=1. On `rd_sdram_ack`, increment `rd_idx` and go to GAP.
  - GAP: after GAP_CYC cycles, go to SYNC if `rd_idx` == FRAME_BURSTS, otherwise go to ARM.
- `frame_valid` is set when the first write frame completes and is never cleared except by reset.
- **Mid-frame frame start**
  - A `wr_frame_start` seen in ARM or GAP restarts the current buffer: `wr_idx`←0, no buffer toggle.
  - A `wr_frame_start` seen in REQ is latched; the restart happens after the ack.
  - `rd_frame_start` behaves the same for the read channel, except it reselects `rd_buf` ← `done_buf`.
- **Request rules**
  - A request is never withdrawn before its ack.
  - Both requests may be high together; the controller arbitrates between them.
  - An ack that arrives while its request is low is ignored.
- Reset mid-operation: all state returns to the reset values immediately. An in-flight controller burst is not tracked.

## Timing
- Reset values:
  - `wr_sdram_req`=0, `rd_sdram_req`=0.
  - `wr_addr`=0, `rd_addr`=0.
  - `wr_buf`=0, `rd_buf`=0, `done_buf`=0, `frame_valid`=0.
  - Both channels in SYNC.
- All outputs are registered.
- A request rises 1 cycle after the cycle in which the FIFO threshold is met in ARM.
- A request falls in the cycle after the ack is sampled.
- Addresses update in that same cycle, so `wr_addr`/`rd_addr` are stable for the whole time the request is high.
- Minimum low time between requests on a channel is GAP_CYC+1 cycles.
- `wr_idx` compares against FRAME_BURSTS after the increment. It never exceeds FRAME_BURSTS.

## Test plan
- **Threshold:** after init, pulse `wr_frame_start`, drive `wfifo_rdusedw`=511 → `wr_sdram_req` stays 0. Drive 512 → `wr_sdram_req`=1 one cycle later, with `wr_addr`=0.
- **Handshake:** hold `wr_sdram_req` high for 600 cycles, then pulse `wr_sdram_ack` → `wr_sdram_req`=0 on the next cycle, `wr_addr`=1, and the request rises again no sooner than 5 cycles later with the FIFO still full.
- **Frame wrap:** complete 600 write acks → `wr_addr` returns to {1,0}, `frame_valid`=1, and the write channel waits in SYNC for the next `wr_frame_start`.
- **Read side:** with `frame_valid`=1 and `rfifo_wrusedw`=512, pulse `rd_frame_start` → `rd_sdram_req` rises with `rd_addr`={0,0}. With `rfifo_wrusedw`=513, no request.
- **Simultaneous/ignored:** both FIFOs ready → both requests high in the same cycle. A `rd_sdram_ack` pulse while `rd_sdram_req`=0 → no change to `rd_addr`.
- **Mid-operation events:**
  - `wr_frame_start` while in REQ at `wr_idx`=37 → the request is held until the ack, then `wr_idx`=0 and `wr_buf` is unchanged.
  - Assert `rst_n` low during REQ → all outputs are 0 immediately.
